clock_monitor: RTL and testbench

//  Receive-side checker for divided clocks produced by the clock generator.

---
 rtl/clock_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_clock_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// clock_monitor
//   Receive-side checker for divided clocks. Each channel measures the period
//   of its incoming clock in mainclock cycles, compares it with a programmed
//   expected period and reports lock plus a sticky fault flag. Runs entirely
//   in the mainclock domain; in_clocks are treated as asynchronous inputs.
//
// Ports
//   mainclock        in  reference clock, sole clock of the block
//   reset_n          in  asynchronous active-low reset
//   in_clocks        in  clocks under test, one bit per channel
//   expected_period  in  per-channel expected period, channel j at
//                        [j*cnt_width +: cnt_width]; 0 disables the channel
//   clear_fault      in  per-channel sticky-fault clear (1-cycle pulse)
//   measured_period  out last measured period per channel
//   locked           out channel running at its expected period
//   fault            out sticky mismatch/timeout flag per channel
module clock_monitor #(
  parameter int unsigned clock_number = 8,
  parameter int unsigned cnt_width    = 8,
  parameter int unsigned lock_count   = 4
) (
  input  logic                              mainclock,
  input  logic                              reset_n,
  input  logic [clock_number-1:0]           in_clocks,
  input  logic [clock_number*cnt_width-1:0] expected_period,
  input  logic [clock_number-1:0]           clear_fault,
  output logic [clock_number*cnt_width-1:0] measured_period,
  output logic [clock_number-1:0]           locked,
  output logic [clock_number-1:0]           fault
);

  localparam int unsigned MatchWidth = $clog2(lock_count + 1);

  localparam logic [cnt_width-1:0]  CntMax     = '1;
  localparam logic [cnt_width-1:0]  CntOne     = cnt_width'(1);
  localparam logic [cnt_width:0]    SampleOne  = (cnt_width + 1)'(1);
  localparam logic [MatchWidth-1:0] MatchOne   = MatchWidth'(1);
  localparam logic [MatchWidth-1:0] MatchLast  = MatchWidth'(lock_count - 1);

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StLocked
  } state_e;

  for (genvar j = 0; j < clock_number; j++) begin : g_ch

    logic                  sync1_q, sync2_q, prev_q, edge_q;
    logic [cnt_width-1:0]  cnt_q, cnt_d;
    logic [MatchWidth-1:0] match_q, match_d;
    state_e                state_q, state_d;
    logic [cnt_width-1:0]  meas_q, meas_d;
    logic                  locked_q, locked_d;
    logic                  fault_q, fault_d;
    logic                  fault_set;
    logic [cnt_width:0]    sample_wide;
    logic [cnt_width-1:0]  sample;
    logic [cnt_width-1:0]  expected;
    logic                  is_match;
    logic                  timeout;

    assign expected = expected_period[j*cnt_width +: cnt_width];

    // Sample is one wider than the counter so a saturated count clamps
    // instead of wrapping to zero.
    assign sample_wide = {1'b0, cnt_q} + SampleOne;
    assign sample      = sample_wide[cnt_width] ? CntMax : sample_wide[cnt_width-1:0];
    assign is_match    = (sample == expected);

    // Timeout only matters once the channel has seen an edge; an edge in the
    // same cycle takes priority because it restarts the count.
    assign timeout = (cnt_q == CntMax) && !edge_q && (state_q != StIdle);

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge mainclock or negedge reset_n) begin
      if (!reset_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        prev_q  <= 1'b0;
        edge_q  <= 1'b0;
      end else begin
        sync1_q <= in_clocks[j];
        sync2_q <= sync1_q;
        prev_q  <= sync2_q;
        edge_q  <= sync2_q & ~prev_q;
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      if (edge_q) begin
        cnt_d = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end
    end

    always_comb begin
      state_d   = state_q;
      match_d   = match_q;
      meas_d    = meas_q;
      locked_d  = locked_q;
      fault_set = 1'b0;

      if (expected == '0) begin
        // Disabled channel: still reports the period, never locks or faults.
        state_d  = StIdle;
        match_d  = '0;
        locked_d = 1'b0;
        if (edge_q) begin
          meas_d = sample;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            // First edge only starts the count; no period is known yet.
            match_d  = '0;
            locked_d = 1'b0;
            if (edge_q) begin
              state_d = StMeasure;
            end
          end

          StMeasure: begin
            if (edge_q) begin
              meas_d = sample;
              if (is_match) begin
                match_d = match_q + MatchOne;
                if (match_q == MatchLast) begin
                  state_d  = StLocked;
                  locked_d = 1'b1;
                end
              end else begin
                match_d = '0;
              end
            end else if (timeout) begin
              state_d  = StIdle;
              match_d  = '0;
              locked_d = 1'b0;
            end
          end

          StLocked: begin
            if (edge_q) begin
              meas_d = sample;
              if (!is_match) begin
                state_d   = StMeasure;
                match_d   = '0;
                locked_d  = 1'b0;
                fault_set = 1'b1;
              end
            end else if (timeout) begin
              state_d   = StIdle;
              match_d   = '0;
              locked_d  = 1'b0;
              fault_set = 1'b1;
            end
          end

          default: begin
            state_d  = StIdle;
            match_d  = '0;
            locked_d = 1'b0;
          end
        endcase
      end
    end

    // A new fault outranks a clear arriving in the same cycle.
    always_comb begin
      fault_d = fault_q;
      if (fault_set) begin
        fault_d = 1'b1;
      end else if (clear_fault[j]) begin
        fault_d = 1'b0;
      end
    end

    always_ff @(posedge mainclock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q    <= '0;
        match_q  <= '0;
        state_q  <= StIdle;
        meas_q   <= '0;
        locked_q <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        match_q  <= match_d;
        state_q  <= state_d;
        meas_q   <= meas_d;
        locked_q <= locked_d;
        fault_q  <= fault_d;
      end
    end

    assign measured_period[j*cnt_width +: cnt_width] = meas_q;
    assign locked[j]                                 = locked_q;
    assign fault[j]                                  = fault_q;

  end : g_ch

endmodule

// File: tb/tb_clock_monitor.sv
// Testbench for clock_monitor. Per-channel test clocks are generated from
// mainclock negedges; expected outputs are queued by the stimulus thread and
// compared against the DUT by an independent monitor process.
module tb_clock_monitor;

  localparam int N = 8;
  localparam int W = 8;

  logic           mainclock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_clocks;
  logic [N*W-1:0] expected_period;
  logic [N-1:0]   clear_fault;
  logic [N*W-1:0] measured_period;
  logic [N-1:0]   locked;
  logic [N-1:0]   fault;

  int half[N]     = '{default: 0};
  int ph[N]       = '{default: 0};
  int rise_cnt[N] = '{default: 0};

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           test;
    int           ch;
    logic [W-1:0] meas;
    logic         lk;
    logic         flt;
    bit           chk_meas;
  } exp_t;

  exp_t sb[$];

  clock_monitor #(
    .clock_number(N),
    .cnt_width   (W),
    .lock_count  (4)
  ) dut (
    .mainclock      (mainclock),
    .reset_n        (reset_n),
    .in_clocks      (in_clocks),
    .expected_period(expected_period),
    .clear_fault    (clear_fault),
    .measured_period(measured_period),
    .locked         (locked),
    .fault          (fault)
  );

  always #5 mainclock = ~mainclock;

  // Test clock generator: period = 2*half mainclock cycles, half==0 holds low.
  initial begin
    in_clocks = '0;
    forever begin
      @(negedge mainclock);
      for (int j = 0; j < N; j++) begin
        if (half[j] == 0) begin
          in_clocks[j] = 1'b0;
          ph[j]        = 0;
        end else begin
          ph[j]++;
          if (ph[j] >= half[j]) begin
            ph[j] = 0;
            if (!in_clocks[j]) rise_cnt[j]++;
            in_clocks[j] = ~in_clocks[j];
          end
        end
      end
    end
  end

  // Monitor: drains the scoreboard each cycle, away from the active edge.
  initial begin
    exp_t         e;
    logic [W-1:0] am;
    forever begin
      @(negedge mainclock);
      #3;
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        am = measured_period[e.ch*W +: W];
        if (e.chk_meas) begin
          checks++;
          if (am !== e.meas) begin
            failures++;
            $display("FAIL t%0d ch%0d measured_period got %0d expected %0d",
                     e.test, e.ch, am, e.meas);
          end
        end
        checks++;
        if (locked[e.ch] !== e.lk) begin
          failures++;
          $display("FAIL t%0d ch%0d locked got %b expected %b", e.test, e.ch, locked[e.ch], e.lk);
        end
        checks++;
        if (fault[e.ch] !== e.flt) begin
          failures++;
          $display("FAIL t%0d ch%0d fault got %b expected %b", e.test, e.ch, fault[e.ch], e.flt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic expect_ch(input int test, input int ch, input int meas, input logic lk,
                           input logic flt, input bit cm);
    exp_t e;
    e.test     = test;
    e.ch       = ch;
    e.meas     = W'(meas);
    e.lk       = lk;
    e.flt      = flt;
    e.chk_meas = cm;
    sb.push_back(e);
  endtask

  task automatic set_exp(input int ch, input int val);
    expected_period[ch*W +: W] = W'(val);
  endtask

  // Polls at negedge+1 so a rise is seen in the cycle it happens.
  task automatic wait_count(input int ch, input int target);
    for (int i = 0; i < 2000; i++) begin
      if (rise_cnt[ch] >= target) return;
      @(negedge mainclock);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL wait ch%0d rises got %0d required %0d", ch, rise_cnt[ch], target);
  endtask

  // Rise seen at negedge -> sync, sync, edge pulse, output update: 4 posedges.
  task automatic settle();
    repeat (4) @(posedge mainclock);
    @(negedge mainclock);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge mainclock);
    #2;
  endtask

  initial begin
    int m;
    reset_n         = 1'b0;
    expected_period = '0;
    clear_fault     = '0;

    // Reset state
    cycles(3);
    for (int j = 0; j < N; j++) expect_ch(0, j, 0, 1'b0, 1'b0, 1'b1);
    cycles(1);
    reset_n = 1'b1;
    cycles(1);

    set_exp(0, 4);  half[0] = 2;
    set_exp(1, 4);  half[1] = 2;
    set_exp(2, 0);  half[2] = 4;
    set_exp(3, 4);  half[3] = 2;
    set_exp(4, 4);  half[4] = 2;
    set_exp(5, 6);  half[5] = 3;
    set_exp(6, 8);  half[6] = 4;
    set_exp(7, 10); half[7] = 5;

    // 1: period 4 locks after the 5th rising edge
    wait_count(0, 4);
    settle();
    expect_ch(1, 0, 4, 1'b0, 1'b0, 1'b1);
    expect_ch(4, 2, 0, 1'b0, 1'b0, 1'b0);
    wait_count(0, 5);
    settle();
    expect_ch(1, 0, 4, 1'b1, 1'b0, 1'b1);
    expect_ch(4, 2, 8, 1'b0, 1'b0, 1'b1);

    // 2: switch ch0 to period 6 -> fault, then relock at expected 6
    wait_count(0, rise_cnt[0] + 1);
    half[0] = 3;
    m = rise_cnt[0];
    wait_count(0, m + 1);
    settle();
    expect_ch(2, 0, 6, 1'b0, 1'b1, 1'b1);
    set_exp(0, 6);
    wait_count(0, m + 4);
    settle();
    expect_ch(2, 0, 6, 1'b0, 1'b1, 1'b1);
    wait_count(0, m + 5);
    settle();
    expect_ch(2, 0, 6, 1'b1, 1'b1, 1'b1);
    expect_ch(4, 2, 8, 1'b0, 1'b0, 1'b1);

    // 3: stop ch1 -> timeout after ~255 cycles, then clear and relock from idle
    expect_ch(3, 1, 4, 1'b1, 1'b0, 1'b1);
    half[1] = 0;
    cycles(200);
    expect_ch(3, 1, 4, 1'b1, 1'b0, 1'b1);
    cycles(80);
    expect_ch(3, 1, 4, 1'b0, 1'b1, 1'b1);
    @(negedge mainclock);
    #1 clear_fault[1] = 1'b1;
    @(negedge mainclock);
    #1 clear_fault[1] = 1'b0;
    #1 expect_ch(3, 1, 4, 1'b0, 1'b0, 1'b1);
    half[1] = 2;
    m = rise_cnt[1];
    wait_count(1, m + 4);
    settle();
    expect_ch(3, 1, 4, 1'b0, 1'b0, 1'b1);
    wait_count(1, m + 5);
    settle();
    expect_ch(3, 1, 4, 1'b1, 1'b0, 1'b1);

    // 5: clear_fault coincident with the mismatch update on ch3
    expect_ch(5, 3, 4, 1'b1, 1'b0, 1'b1);
    wait_count(3, rise_cnt[3] + 1);
    half[3] = 3;
    m = rise_cnt[3];
    wait_count(3, m + 1);
    repeat (3) @(posedge mainclock);
    #1 clear_fault[3] = 1'b1;
    @(posedge mainclock);
    #1 clear_fault[3] = 1'b0;
    @(negedge mainclock);
    #2 expect_ch(5, 3, 6, 1'b0, 1'b1, 1'b1);
    cycles(1);
    expect_ch(5, 3, 6, 1'b0, 1'b1, 1'b0);
    set_exp(3, 6);

    // 6: reset mid-lock on all channels, then relock
    cycles(80);
    for (int j = 0; j < N; j++)
      expect_ch(6, j, 2 * half[j], (j != 2), (j == 0 || j == 3), 1'b1);
    @(negedge mainclock);
    #1 reset_n = 1'b0;
    #1;
    for (int j = 0; j < N; j++) expect_ch(6, j, 0, 1'b0, 1'b0, 1'b1);
    cycles(2);
    reset_n = 1'b1;
    cycles(150);
    for (int j = 0; j < N; j++)
      expect_ch(6, j, 2 * half[j], (j != 2), 1'b0, 1'b1);

    cycles(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard left %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
